// File: rtl/rat_int_pkg.sv
// Shared definitions for the RAT interrupt controller.
//   int_state_t      : controller FSM states (idle / request / in service)
//   DEF_*_PORT       : default I/O port addresses of the mask, pending and ID registers
package rat_int_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } int_state_t;

   localparam logic [7:0] DEF_MASK_PORT = 8'h20;
   localparam logic [7:0] DEF_PEND_PORT = 8'h21;
   localparam logic [7:0] DEF_ID_PORT   = 8'h22;

endpackage

// File: rtl/rat_int_prio_enc.sv
// Combinational priority encoder used to pick the winning interrupt source.
// The search starts at index ptr and wraps modulo N; with ptr tied to 0 this
// is a plain lowest-index-wins encoder.
//   vec   in  N  request vector
//   ptr   in  3  index the search starts from (must be < N)
//   valid out 1  at least one bit of vec is set
//   idx   out 3  index of the first set bit found
module rat_int_prio_enc #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] vec,
   input  logic [2:0]   ptr,
   output logic         valid,
   output logic [2:0]   idx
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   always_comb begin
      int unsigned j;
      logic [IW-1:0] sel;
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      sel   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j   = (32'(ptr) + i) % N;
         sel = IW'(j);
         if (!valid && vec[sel]) begin
            valid = 1'b1;
            idx   = 3'(j);
         end
      end
   end

endmodule

// File: rtl/rat_int_ctrl.sv
// Interrupt controller for the RAT CPU.
// Latches rising edges of the IRQ lines as pending, masks them, raises INT to
// the control unit, records the winning source on INT_ACK and waits for
// INT_DONE. Mask / pending / current-ID registers are readable on the I/O bus;
// mask is writable, pending is write-1-to-clear.
// Build option: define RAT_INT_ROTATE_EN for round-robin source selection;
// otherwise fixed priority (lowest index wins).
//   CLK      in  1        system clock
//   RESET    in  1        synchronous active-high reset
//   IRQ      in  NUM_SRC  asynchronous rising-edge interrupt sources
//   I_FLAG   in  1        CU interrupt-enable flag
//   INT_ACK  in  1        CU entered its interrupt cycle (pulse)
//   INT_DONE in  1        CU executed RETIE/RETID (pulse)
//   PORT_ID  in  8        I/O port address
//   OUT_PORT in  8        I/O write data
//   IO_STRB  in  1        I/O write strobe
//   INT      out 1        registered interrupt request to the CU
//   RD_DATA  out 8        read data for PORT_ID, 0 when no register matches
//   RD_HIT   out 1        PORT_ID addresses one of the three registers
module rat_int_ctrl
   import rat_int_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 8,
   parameter logic [7:0]  MASK_PORT = DEF_MASK_PORT,
   parameter logic [7:0]  PEND_PORT = DEF_PEND_PORT,
   parameter logic [7:0]  ID_PORT   = DEF_ID_PORT
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_SRC-1:0] IRQ,
   input  logic               I_FLAG,
   input  logic               INT_ACK,
   input  logic               INT_DONE,
   input  logic [7:0]         PORT_ID,
   input  logic [7:0]         OUT_PORT,
   input  logic               IO_STRB,
   output logic               INT,
   output logic [7:0]         RD_DATA,
   output logic               RD_HIT
);

   int_state_t         state, state_nxt;
   logic [NUM_SRC-1:0] sync1, sync2, sync3;
   logic [NUM_SRC-1:0] mask, pending;
   logic [NUM_SRC-1:0] edge_vec, req_vec, w1c_clr, ack_clr;
   logic [2:0]         cur_id;
   logic [2:0]         ptr;
   logic               win_valid;
   logic [2:0]         win_idx;
   logic               wr_mask, wr_pend;
   logic               ack_take;

   assign wr_mask  = IO_STRB && (PORT_ID == MASK_PORT);
   assign wr_pend  = IO_STRB && (PORT_ID == PEND_PORT);
   assign edge_vec = sync2 & ~sync3;
   assign req_vec  = pending & mask;
   assign w1c_clr  = wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0;

   rat_int_prio_enc #(.N(NUM_SRC)) u_prio_enc (
      .vec   (req_vec),
      .ptr   (ptr),
      .valid (win_valid),
      .idx   (win_idx)
   );

`ifdef RAT_INT_ROTATE_EN
   always_ff @(posedge CLK) begin
      if (RESET)
         ptr <= '0;
      else if (ack_take)
         ptr <= (win_idx == 3'(NUM_SRC - 1)) ? 3'd0 : win_idx + 3'd1;
   end
`else
   assign ptr = '0;
`endif

   // Synchronizer plus edge-detect flop.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= IRQ;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         INT     <= 1'b0;
         mask    <= '0;
         pending <= '0;
         cur_id  <= '0;
      end else begin
         state   <= state_nxt;
         INT     <= (state_nxt == ST_REQ);
         // Clears are applied before the OR so a new edge in the same cycle survives.
         pending <= (pending & ~w1c_clr & ~ack_clr) | edge_vec;
         if (wr_mask)
            mask <= OUT_PORT[NUM_SRC-1:0];
         if (ack_take)
            cur_id <= win_idx;
      end
   end

   always_comb begin
      state_nxt = state;
      ack_take  = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((|req_vec) && I_FLAG)
               state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (INT_ACK) begin
               state_nxt = ST_SERVICE;
               ack_take  = win_valid;
            end else if (!I_FLAG || (req_vec == '0)) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (INT_DONE)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ack_clr = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++)
         ack_clr[i] = ack_take && (win_idx == 3'(i));
   end

   always_comb begin
      RD_DATA = '0;
      RD_HIT  = 1'b0;
      if (PORT_ID == MASK_PORT) begin
         RD_HIT  = 1'b1;
         RD_DATA = 8'(mask);
      end else if (PORT_ID == PEND_PORT) begin
         RD_HIT  = 1'b1;
         RD_DATA = 8'(pending);
      end else if (PORT_ID == ID_PORT) begin
         RD_HIT  = 1'b1;
         RD_DATA = {(state == ST_SERVICE), 4'b0000, cur_id};
      end
   end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: directed scenarios followed by random
// transactions, checked against a transaction-level model through a
// cycle-stamped expectation queue drained by an independent monitor.
module tb_rat_int_ctrl;

   localparam int unsigned NSRC = 8;
   localparam logic [7:0] P_MASK = 8'h20;
   localparam logic [7:0] P_PEND = 8'h21;
   localparam logic [7:0] P_ID   = 8'h22;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] IRQ = '0;
   logic       I_FLAG = 1'b0;
   logic       INT_ACK = 1'b0;
   logic       INT_DONE = 1'b0;
   logic [7:0] PORT_ID = '0;
   logic [7:0] OUT_PORT = '0;
   logic       IO_STRB = 1'b0;
   logic       INT;
   logic [7:0] RD_DATA;
   logic       RD_HIT;

   rat_int_ctrl #(
      .NUM_SRC   (NSRC),
      .MASK_PORT (P_MASK),
      .PEND_PORT (P_PEND),
      .ID_PORT   (P_ID)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .IRQ      (IRQ),
      .I_FLAG   (I_FLAG),
      .INT_ACK  (INT_ACK),
      .INT_DONE (INT_DONE),
      .PORT_ID  (PORT_ID),
      .OUT_PORT (OUT_PORT),
      .IO_STRB  (IO_STRB),
      .INT      (INT),
      .RD_DATA  (RD_DATA),
      .RD_HIT   (RD_HIT)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // kind: 0 = INT, 1 = RD_DATA, 2 = RD_HIT
   typedef struct {
      int unsigned cyc;
      int          kind;
      logic [7:0]  val;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Transaction-level reference state.
   logic [7:0] m_mask, m_pend;
   bit         m_iflag, m_serv;
   int         m_cur, m_ptr;

   always @(negedge CLK) begin
      int i;
      logic [7:0] act;
      i = 0;
      while (i < exp_q.size()) begin
         if (exp_q[i].cyc == cyc) begin
            case (exp_q[i].kind)
               0:       act = {7'b0, INT};
               1:       act = RD_DATA;
               default: act = {7'b0, RD_HIT};
            endcase
            checks++;
            if (act !== exp_q[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d actual=%02h expected=%02h",
                        exp_q[i].name, cyc, act, exp_q[i].val);
            end
            exp_q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic push_exp(int unsigned c, int kind, logic [7:0] v, string nm);
      exp_t e;
      e.cyc = c; e.kind = kind; e.val = v; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      repeat (6) tick();
   endtask

   function automatic logic m_int();
      return !m_serv && m_iflag && ((m_pend & m_mask) != 8'h00);
   endfunction

   function automatic int m_winner();
      logic [7:0] r;
      r = m_pend & m_mask;
      for (int k = 0; k < NSRC; k++) begin
         int j;
         j = (m_ptr + k) % NSRC;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_mask = '0; m_pend = '0; m_serv = 0; m_cur = 0; m_ptr = 0;
   endtask

   task automatic check_all();
      logic [7:0] idv, other;
      idv = {m_serv, 4'b0000, 3'(m_cur)};
      PORT_ID = P_MASK;
      push_exp(cyc, 1, m_mask, "rd_mask");
      push_exp(cyc, 2, 8'h01, "hit_mask");
      push_exp(cyc, 0, {7'b0, m_int()}, "int");
      tick();
      PORT_ID = P_PEND;
      push_exp(cyc, 1, m_pend, "rd_pend");
      push_exp(cyc, 2, 8'h01, "hit_pend");
      tick();
      PORT_ID = P_ID;
      push_exp(cyc, 1, idv, "rd_id");
      push_exp(cyc, 2, 8'h01, "hit_id");
      tick();
      other = 8'($urandom_range(0, 255));
      if (other >= P_MASK && other <= P_ID) other = 8'h7F;
      PORT_ID = other;
      push_exp(cyc, 1, 8'h00, "rd_nohit");
      push_exp(cyc, 2, 8'h00, "hit_nohit");
      tick();
   endtask

   task automatic act_mask(logic [7:0] v);
      IO_STRB = 1; PORT_ID = P_MASK; OUT_PORT = v;
      tick();
      IO_STRB = 0;
      m_mask = v;
      settle(); check_all();
   endtask

   task automatic act_w1c(logic [7:0] v);
      IO_STRB = 1; PORT_ID = P_PEND; OUT_PORT = v;
      tick();
      IO_STRB = 0;
      m_pend = m_pend & ~v;
      settle(); check_all();
   endtask

   task automatic act_pulse(logic [7:0] v);
      IRQ = v;
      tick(); tick();
      IRQ = '0;
      m_pend = m_pend | v;
      settle(); check_all();
   endtask

   task automatic act_iflag(bit b);
      I_FLAG = b;
      m_iflag = b;
      settle(); check_all();
   endtask

   task automatic act_ack();
      bit was_req;
      int w;
      was_req = m_int();
      INT_ACK = 1;
      tick();
      INT_ACK = 0;
      if (was_req) begin
         w = m_winner();
         m_serv = 1;
         if (w >= 0) begin
            m_cur = w;
            m_pend[w] = 1'b0;
`ifdef RAT_INT_ROTATE_EN
            m_ptr = (w + 1) % NSRC;
`endif
         end
      end
      settle(); check_all();
   endtask

   task automatic act_done();
      INT_DONE = 1;
      tick();
      INT_DONE = 0;
      m_serv = 0;
      settle(); check_all();
   endtask

   task automatic act_reset();
      RESET = 1;
      tick();
      RESET = 0;
      model_reset();
      check_all();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      m_iflag = 0;

      // Reset with all lines high: everything reads zero while in reset.
      IRQ = 8'hFF; RESET = 1;
      tick(); tick();
      check_all();
      IRQ = '0;
      tick();
      RESET = 0;
      tick();
      check_all();

      // Single source, edge-to-INT latency and acknowledge.
      act_mask(8'h04);
      I_FLAG = 1; m_iflag = 1;
      push_exp(cyc + 5, 0, 8'h01, "int_latency");
      act_pulse(8'h04);
      act_ack();
      push_exp(cyc, 0, 8'h00, "int_in_service");
      act_done();

      // Two simultaneous sources.
      act_reset();
      act_iflag(1);
      act_mask(8'hFF);
      act_pulse(8'h22);
      act_ack();
      act_done();
      act_ack();
      act_done();
      act_pulse(8'h42);
      act_ack();
      act_done();
      act_ack();
      act_done();

      // I_FLAG drop while requesting.
      act_reset();
      act_mask(8'h04);
      act_iflag(1);
      act_pulse(8'h04);
      I_FLAG = 0;
      push_exp(cyc + 1, 0, 8'h00, "int_drop_next");
      m_iflag = 0;
      settle(); check_all();
      act_iflag(1);
      act_ack();
      act_done();

      // W1C coinciding with a new edge on the same bit.
      act_reset();
      act_iflag(1);
      act_pulse(8'h08);
      IRQ = 8'h08;
      tick(); tick();
      IO_STRB = 1; PORT_ID = P_PEND; OUT_PORT = 8'h08; IRQ = '0;
      tick();
      IO_STRB = 0;
      m_pend = m_pend | 8'h08;
      settle(); check_all();
      act_mask(8'hFF);
      act_ack();
      act_pulse(8'h10);
      act_done();

      // Reset while in service.
      act_ack();
      act_reset();

      // Random transactions.
      act_iflag(1);
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0:       act_mask(8'($urandom_range(0, 255)));
            1, 2, 3: act_pulse(8'($urandom_range(0, 255)));
            4:       act_w1c(8'($urandom_range(0, 255)));
            5:       act_iflag($urandom_range(0, 3) != 0);
            6, 7:    act_ack();
            8:       act_done();
            default: begin
               if ($urandom_range(0, 1) == 1) act_reset();
               else act_iflag(1);
            end
         endcase
      end

      repeat (4) tick();
      if (exp_q.size() != 0) begin
         $display("FAIL leftover_expectations actual=%0d expected=0", exp_q.size());
         failures += exp_q.size();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
